uiudp_user_wr: RTL and testbench
================================

UIUDP_USER_WR -- requirements
Module: uiudp_user_wr

Interface
REQ-001 SHALL have parameter PKT_LEN, default 1024: maximum UDP payload bytes per request (1..FIFO_DEPTH).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2048: byte buffer depth, power of two.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 125000: idle cycles before a partial packet is flushed.
REQ-004 SHALL have port I_W_udp_clk  in  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port I_reset_n  in  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port I_app_valid  in  1: application byte is valid.
REQ-007 SHALL have port I_app_data  in  8: application byte.
REQ-008 SHALL have port O_app_ready  out  1: block accepts the byte; transfer occurs when valid and ready are both high.
REQ-009 SHALL have port O_W_udp_req  out  1: write request to the UDP transmit user interface.
REQ-010 SHALL have port O_W_udp_len  out  16: payload length of the requested packet.
REQ-011 SHALL have port I_W_udp_busy  in  1: UDP transmitter grants the request and can take data.
REQ-012 SHALL have port O_W_udp_valid  out  1: payload byte valid.
REQ-013 SHALL have port O_W_udp_data  out  8: payload byte.
REQ-014 SHALL have port O_pkt_cnt  out  16: number of packets fully sent, wrapping modulo 2^16.

Function
REQ-015 SHALL buffer accepted bytes in a FIFO; O_app_ready = (count < FIFO_DEPTH), with count being the FIFO occupancy.
REQ-016 SHALL allow a write and a read in the same cycle; count is unchanged in that case, and full/empty are evaluated on the pre-edge count.
REQ-017 SHALL use states IDLE, REQ, SEND and DONE.
REQ-018 IDLE->REQ SHALL occur when count >= PKT_LEN, or on a flush condition (REQ-030).
REQ-019 On entry to REQ, the block SHALL latch O_W_udp_len = min(count, PKT_LEN); O_W_udp_len is held stable while O_W_udp_req is high.
REQ-020 In REQ, O_W_udp_req SHALL stay high until I_W_udp_busy is sampled high; on that edge the state goes to SEND and O_W_udp_req drops.
REQ-021 In SEND, O_W_udp_valid SHALL be high for exactly O_W_udp_len consecutive cycles, starting the cycle after busy is sampled.
REQ-022 In SEND, O_W_udp_data SHALL carry the FIFO bytes in arrival order, with no gaps.
REQ-023 After the last byte, the block SHALL go to DONE, increment O_pkt_cnt, and drive O_W_udp_valid low.
REQ-024 DONE->IDLE SHALL occur once I_W_udp_busy is sampled low; a new request is never raised while busy is high.
REQ-025 O_W_udp_data SHALL be 8'h00 whenever O_W_udp_valid is low.
REQ-026 The application SHALL be able to write during REQ, SEND and DONE; bytes written during SEND join later packets only.
REQ-027 If busy falls during SEND, the block SHALL still complete the packet; no abort path exists.

Reset
REQ-028 While I_reset_n is low, the outputs SHALL be: O_W_udp_req=0, O_W_udp_valid=0, O_W_udp_data=0, O_W_udp_len=0, O_pkt_cnt=0, O_app_ready=0; the FIFO is empty, the state is IDLE and the timer is 0.
REQ-029 O_app_ready SHALL rise on the first clock edge after reset release; a reset in mid-SEND discards the partial packet and all buffered data.

Configuration
REQ-030 With UIUDP_WR_TIMEOUT_EN defined:
- A timer SHALL count cycles in IDLE while 0 < count < PKT_LEN and no byte is accepted; it clears on any accepted byte or on leaving IDLE.
- When the timer reaches TIMEOUT_CYC, the block SHALL flush by taking IDLE->REQ with len = count.
REQ-031 Without UIUDP_WR_TIMEOUT_EN, no timer logic SHALL exist, and only full PKT_LEN packets are ever sent.

Verification
REQ-032 Write 1024 bytes 0x00..0xFF repeating, busy returned 3 cycles after req -> the bench SHALL see req with len=1024, then 1024 contiguous valid bytes matching the input, then O_pkt_cnt=1.
REQ-033 Write 2048 bytes with busy held low -> the bench SHALL see O_app_ready=0 after byte 2048, req high with len=1024, and no data lost once busy rises.
REQ-034 With the macro defined and TIMEOUT_CYC=100, write 10 bytes then idle -> the bench SHALL see req 100 cycles after the last write, with len=10.
REQ-035 Without the macro, run the same stimulus as REQ-034 -> the bench SHALL see no req for 10000 cycles.
REQ-036 Continuous writes during SEND -> the bench SHALL see the second packet carry the bytes following the first packet, in order, with no duplicates.
REQ-037 Assert I_reset_n low on the 500th SEND byte -> the bench SHALL see valid and req drop immediately, and after release, count=0 and O_pkt_cnt=0.

Source files
------------

// File: rtl/uiudp_user_wr_if.sv
// -----------------------------------------------------------------------------
// uiudp_user_wr_if
// Bundle of the application byte stream and the UDP transmit user interface
// used by uiudp_user_wr.
//   I_app_valid / I_app_data / O_app_ready : application byte handshake
//   O_W_udp_req / O_W_udp_len / I_W_udp_busy : packet request / grant
//   O_W_udp_valid / O_W_udp_data             : payload byte stream
// Modports:
//   master : the uiudp_user_wr side (drives O_* members)
//   slave  : the application / UDP transmitter side (drives I_* members)
// -----------------------------------------------------------------------------
interface uiudp_user_wr_if;
  logic        I_app_valid;
  logic [7:0]  I_app_data;
  logic        O_app_ready;
  logic        O_W_udp_req;
  logic [15:0] O_W_udp_len;
  logic        I_W_udp_busy;
  logic        O_W_udp_valid;
  logic [7:0]  O_W_udp_data;

  modport master (
    input  I_app_valid, I_app_data, I_W_udp_busy,
    output O_app_ready, O_W_udp_req, O_W_udp_len, O_W_udp_valid, O_W_udp_data
  );

  modport slave (
    output I_app_valid, I_app_data, I_W_udp_busy,
    input  O_app_ready, O_W_udp_req, O_W_udp_len, O_W_udp_valid, O_W_udp_data
  );
endinterface

// File: rtl/uiudp_user_wr.sv
// -----------------------------------------------------------------------------
// uiudp_user_wr
// Buffers application bytes in a FIFO and hands them to a UDP transmit user
// interface as packets of PKT_LEN bytes (request / busy-grant / byte stream).
// Ports:
//   I_W_udp_clk : single clock, rising edge
//   I_reset_n   : asynchronous active-low reset
//   bus         : uiudp_user_wr_if.master (application + UDP user signals)
//   O_pkt_cnt   : packets fully sent, wraps modulo 2^16
// Parameters: PKT_LEN (max payload per request), FIFO_DEPTH (power of two),
//   TIMEOUT_CYC (idle cycles before a partial packet is flushed).
// Optional feature: define UIUDP_WR_TIMEOUT_EN to enable the flush timer that
//   sends a short packet after TIMEOUT_CYC idle cycles. Without it only full
//   PKT_LEN packets are sent and no timer logic exists.
// -----------------------------------------------------------------------------
module uiudp_user_wr #(
  parameter int PKT_LEN     = 1024,
  parameter int FIFO_DEPTH  = 2048,
  parameter int TIMEOUT_CYC = 125000
) (
  input  logic                  I_W_udp_clk,
  input  logic                  I_reset_n,
  uiudp_user_wr_if.master       bus,
  output logic [15:0]           O_pkt_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PKT_C   = CW'(PKT_LEN);

  // Parameter sanity check at elaboration time.
  if (PKT_LEN < 1 || PKT_LEN > FIFO_DEPTH || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("uiudp_user_wr: illegal PKT_LEN / FIFO_DEPTH / TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ready_en;
  logic [15:0]   len_q;
  logic [15:0]   send_cnt;
  logic          wr_en, rd_en, last_byte, pkt_ready, flush;

  // ready_en is cleared by reset so O_app_ready stays low until the first
  // edge after release; full is judged on the pre-edge count.
  assign bus.O_app_ready = ready_en && (count < DEPTH_C);
  assign wr_en           = bus.I_app_valid && bus.O_app_ready;
  assign rd_en           = (state == SEND);
  assign pkt_ready       = (count >= PKT_C);
  assign last_byte       = (send_cnt == len_q - 16'd1);
  assign bus.O_W_udp_len = len_q;

`ifdef UIUDP_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer;
  logic          timer_run;

  // Counts idle cycles with a partial packet waiting; the flush fires on the
  // cycle the timer would reach TIMEOUT_CYC and holds while the transmitter
  // is still busy, so the counter never wraps.
  assign timer_run = (state == IDLE) && (count != '0) && !pkt_ready && !wr_en;
  assign flush     = timer_run && (timer >= TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge I_W_udp_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      timer <= '0;
    end else if (timer_run) begin
      if (!flush) timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end
`else
  assign flush = 1'b0;
`endif

  // State register.
  always_ff @(posedge I_W_udp_clk or negedge I_reset_n) begin
    if (!I_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic. A request is only raised while busy is low.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!bus.I_W_udp_busy && (pkt_ready || flush)) state_nxt = REQ;
      REQ:  if (bus.I_W_udp_busy) state_nxt = SEND;
      SEND: if (last_byte) state_nxt = DONE;
      DONE: if (!bus.I_W_udp_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state; the payload is read straight from the
  // FIFO head so data and valid line up in the same cycle.
  always_comb begin
    bus.O_W_udp_req   = 1'b0;
    bus.O_W_udp_valid = 1'b0;
    bus.O_W_udp_data  = 8'h00;
    case (state)
      REQ:  bus.O_W_udp_req = 1'b1;
      SEND: begin
        bus.O_W_udp_valid = 1'b1;
        bus.O_W_udp_data  = mem[rd_ptr];
      end
      default: ;
    endcase
  end

  // Storage array has no reset; its contents are qualified by the pointers.
  always_ff @(posedge I_W_udp_clk) begin
    if (wr_en) mem[wr_ptr] <= bus.I_app_data;
  end

  // FIFO pointers/occupancy, length latch, byte counter and packet counter.
  always_ff @(posedge I_W_udp_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      ready_en  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      len_q     <= '0;
      send_cnt  <= '0;
      O_pkt_cnt <= '0;
    end else begin
      ready_en <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A flush only happens below PKT_LEN, so min(count, PKT_LEN) reduces
      // to this select.
      if (state == IDLE && state_nxt == REQ)
        len_q <= pkt_ready ? 16'(PKT_LEN) : 16'(count);
      if (state == SEND) send_cnt <= send_cnt + 16'd1;
      else               send_cnt <= '0;
      if (state == SEND && last_byte) O_pkt_cnt <= O_pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uiudp_user_wr.sv
// -----------------------------------------------------------------------------
// tb_uiudp_user_wr
// Self-checking bench for uiudp_user_wr (PKT_LEN=1024, FIFO_DEPTH=2048,
// TIMEOUT_CYC=100). Table of packet transactions plus hand-written sequences
// for FIFO full, flush timer (or its absence), streaming during SEND and
// reset in mid-packet. A negedge monitor compares every payload byte with a
// queue of accepted bytes.
// -----------------------------------------------------------------------------
module tb_uiudp_user_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pkt_cnt;
  int          n_vec  = 0;
  int          n_miss = 0;
  int          exp_pkts = 0;
  logic [7:0]  exp_q[$];

  uiudp_user_wr_if bus();

  uiudp_user_wr #(
    .PKT_LEN    (1024),
    .FIFO_DEPTH (2048),
    .TIMEOUT_CYC(100)
  ) dut (
    .I_W_udp_clk(clk),
    .I_reset_n  (rst_n),
    .bus        (bus.master),
    .O_pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbytes;
    logic [7:0]  first;
    int          busy_dly;
    bit          hold_busy;
    logic [15:0] exp_len;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Payload monitor: bytes must come out in acceptance order, 0 when idle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.O_W_udp_valid) begin
        if (exp_q.size() == 0) checkOutput("data_extra", 32'(bus.O_W_udp_data), 32'hFFFF_FFFF);
        else                   checkOutput("data", 32'(bus.O_W_udp_data), 32'(exp_q.pop_front()));
      end else begin
        checkOutput("data_idle_zero", 32'(bus.O_W_udp_data), 32'h0);
      end
    end
  end

  // Present one byte and hold it until accepted; ready is read mid-cycle, so
  // it is the value the DUT sees at the next edge.
  task automatic write_byte(input logic [7:0] d);
    int   guard = 0;
    logic rdy;
    bus.I_app_valid = 1'b1;
    bus.I_app_data  = d;
    do begin
      rdy = bus.O_app_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 5000);
    if (rdy) exp_q.push_back(d);
    else     checkOutput("write_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_run(input int n, input logic [7:0] first);
    logic [7:0] d = first;
    for (int i = 0; i < n; i++) begin
      write_byte(d);
      d++;
    end
    bus.I_app_valid = 1'b0;
    bus.I_app_data  = 8'h00;
  endtask

  // Transmitter side of one packet: wait for req, grant after busy_dly
  // cycles, count contiguous valid cycles, then release busy.
  task automatic run_packet(input logic [15:0] exp_len, input int busy_dly, input bit hold_busy);
    int n = 0;
    int vcnt = 0;
    while (!bus.O_W_udp_req && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("req_seen", 32'(bus.O_W_udp_req), 32'd1);
    checkOutput("req_len", 32'(bus.O_W_udp_len), 32'(exp_len));
    repeat (busy_dly) begin @(posedge clk); #1; end
    checkOutput("req_held", 32'(bus.O_W_udp_req), 32'd1);
    checkOutput("len_held", 32'(bus.O_W_udp_len), 32'(exp_len));
    bus.I_W_udp_busy = 1'b1;
    @(posedge clk); #1;
    if (!hold_busy) bus.I_W_udp_busy = 1'b0;
    checkOutput("req_drop_on_grant", 32'(bus.O_W_udp_req), 32'd0);
    while (bus.O_W_udp_valid && vcnt < int'(exp_len) + 4) begin
      vcnt++;
      @(posedge clk); #1;
    end
    checkOutput("valid_run_len", 32'(vcnt), 32'(exp_len));
    exp_pkts++;
    checkOutput("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts & 16'hFFFF));
    if (hold_busy) begin
      repeat (2) begin
        @(posedge clk); #1;
        checkOutput("no_req_while_busy", 32'(bus.O_W_udp_req), 32'd0);
      end
    end
    bus.I_W_udp_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    write_run(v.nbytes, v.first);
    run_packet(v.exp_len, v.busy_dly, v.hold_busy);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n;
    int   hits;

    vecs[0] = '{1024, 8'h00, 3, 1'b1, 16'd1024};
    vecs[1] = '{1024, 8'h37, 0, 1'b1, 16'd1024};
    vecs[2] = '{1024, 8'hF0, 5, 1'b0, 16'd1024};
    vecs[3] = '{1024, 8'h80, 1, 1'b0, 16'd1024};

    bus.I_app_valid  = 1'b0;
    bus.I_app_data   = 8'h00;
    bus.I_W_udp_busy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req",   32'(bus.O_W_udp_req),   32'd0);
    checkOutput("rst_valid", 32'(bus.O_W_udp_valid), 32'd0);
    checkOutput("rst_data",  32'(bus.O_W_udp_data),  32'd0);
    checkOutput("rst_len",   32'(bus.O_W_udp_len),   32'd0);
    checkOutput("rst_pkt",   32'(pkt_cnt),           32'd0);
    checkOutput("rst_ready", 32'(bus.O_app_ready),   32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 32'(bus.O_app_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_after_edge", 32'(bus.O_app_ready), 32'd1);

    // Single full packets
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // FIFO fills with busy low
    write_run(2048, 8'h40);
    checkOutput("full_ready", 32'(bus.O_app_ready), 32'd0);
    checkOutput("full_req",   32'(bus.O_W_udp_req), 32'd1);
    checkOutput("full_len",   32'(bus.O_W_udp_len), 32'd1024);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("full_ready_hold", 32'(bus.O_app_ready), 32'd0);
    run_packet(16'd1024, 0, 1'b1);
    run_packet(16'd1024, 2, 1'b1);
    checkOutput("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Continuous writes while sending
    fork
      write_run(2048, 8'h11);
      begin
        run_packet(16'd1024, 2, 1'b1);
        run_packet(16'd1024, 2, 1'b1);
      end
    join
    checkOutput("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Partial packet then idle
    write_run(10, 8'hC0);
`ifdef UIUDP_WR_TIMEOUT_EN
    n = 0;
    while (!bus.O_W_udp_req && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("timeout_delay", 32'(n), 32'd100);
    run_packet(16'd10, 1, 1'b1);
`else
    hits = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (bus.O_W_udp_req) hits++;
    end
    checkOutput("no_flush_req", 32'(hits), 32'd0);
    write_run(1014, 8'hCA);
    run_packet(16'd1024, 1, 1'b1);
`endif

    // Reset on the 500th SEND byte
    write_run(1024, 8'h5A);
    n = 0;
    while (!bus.O_W_udp_req && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rs_req", 32'(bus.O_W_udp_req), 32'd1);
    bus.I_W_udp_busy = 1'b1;
    @(posedge clk); #1;
    repeat (499) begin @(posedge clk); #1; end
    checkOutput("rs_mid_valid", 32'(bus.O_W_udp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_valid", 32'(bus.O_W_udp_valid), 32'd0);
    checkOutput("rs_req0",  32'(bus.O_W_udp_req),   32'd0);
    checkOutput("rs_data",  32'(bus.O_W_udp_data),  32'd0);
    checkOutput("rs_ready", 32'(bus.O_app_ready),   32'd0);
    checkOutput("rs_pkt",   32'(pkt_cnt),           32'd0);
    exp_q.delete();
    exp_pkts = 0;
    bus.I_W_udp_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rs_ready_after", 32'(bus.O_app_ready), 32'd1);
    checkOutput("rs_pkt_after",   32'(pkt_cnt),         32'd0);
    checkOutput("rs_no_req",      32'(bus.O_W_udp_req), 32'd0);
    write_run(1024, 8'h01);
    run_packet(16'd1024, 3, 1'b1);
    checkOutput("rs_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
